byte_to_word_packer: RTL and testbench

- Downstream stage of the word-to-byte serializer: collects a stream of bytes, least-significant byte first, and reassembles them into one DATAWIDTH-bit word.
- Emits each completed word with a one-cycle valid pulse.
- Discards a partially assembled word if the byte stream stalls longer than a programmable timeout, and flags it with an error pulse.
- Sits between the byte link and word-level consumers.

---
 rtl/byte_to_word_packer.sv | 120 ++++++++++++
 tb/tb_byte_to_word_packer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/byte_to_word_packer.sv
// Reassembles an LSB-first byte stream into DATAWIDTH-bit words, with an
// optional mid-word idle timeout that discards the partial word.
module byte_to_word_packer #(
  parameter int DATAWIDTH = 16,
  parameter int TIMEOUT   = 8
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic [7:0]                            i_ByteIn,
  input  logic                                  i_ByteInValid,
  output logic [DATAWIDTH-1:0]                  o_Data,
  output logic                                  o_DataValid,
  output logic                                  o_Error,
  output logic                                  o_Busy,
  output logic [$clog2((DATAWIDTH+7)/8):0]      o_ByteCount
);

  localparam int BYTENUM = (DATAWIDTH + 7) / 8;
  localparam int MOD     = DATAWIDTH % 8;
  localparam int LASTW   = (MOD == 0) ? 8 : MOD;
  localparam int CW      = $clog2(BYTENUM) + 1;
  localparam int TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [0:0] {S_IDLE, S_COLLECT} state_t;

  state_t               r_State, w_NextState;
  logic [DATAWIDTH-1:0] r_Buf, w_NextBuf;
  logic [CW-1:0]        r_Count, w_NextCount;
  logic [TW-1:0]        r_Idle, w_NextIdle;
  logic [DATAWIDTH-1:0] w_NextData;
  logic                 w_NextValid;
  logic                 w_NextError;
  logic [DATAWIDTH-1:0] w_Word;
  logic [DATAWIDTH-1:0] w_Slot;

  // Buffer slots start at zero, so OR-ing a shifted byte is a slot write; the
  // final byte is truncated to LASTW bits so any unused upper bits drop out.
  always_comb begin
    w_Word = r_Buf | (DATAWIDTH'(i_ByteIn[LASTW-1:0]) << ((BYTENUM - 1) * 8));
    w_Slot = r_Buf | (DATAWIDTH'(i_ByteIn) << (8 * int'(r_Count)));
  end

  always_comb begin
    w_NextState = r_State;
    w_NextBuf   = r_Buf;
    w_NextCount = r_Count;
    w_NextIdle  = r_Idle;
    w_NextData  = o_Data;
    w_NextValid = 1'b0;
    w_NextError = 1'b0;
    unique case (r_State)
      S_IDLE: begin
        w_NextIdle = '0;
        if (i_ByteInValid) begin
          if (BYTENUM == 1) begin
            w_NextData  = w_Word;
            w_NextValid = 1'b1;
            w_NextCount = '0;
            w_NextBuf   = '0;
          end else begin
            w_NextBuf   = DATAWIDTH'(i_ByteIn);
            w_NextCount = CW'(1);
            w_NextState = S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        if (i_ByteInValid) begin
          w_NextIdle = '0;
          if (r_Count == CW'(BYTENUM - 1)) begin
            w_NextData  = w_Word;
            w_NextValid = 1'b1;
            w_NextCount = '0;
            w_NextBuf   = '0;
            w_NextState = S_IDLE;
          end else begin
            w_NextBuf   = w_Slot;
            w_NextCount = r_Count + CW'(1);
          end
        end else if (TIMEOUT > 0) begin
          if (r_Idle == TW'(TIMEOUT - 1)) begin
            w_NextBuf   = '0;
            w_NextCount = '0;
            w_NextIdle  = '0;
            w_NextError = 1'b1;
            w_NextState = S_IDLE;
          end else begin
            w_NextIdle = r_Idle + TW'(1);
          end
        end
      end
      default: w_NextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_State     <= S_IDLE;
      r_Buf       <= '0;
      r_Count     <= '0;
      r_Idle      <= '0;
      o_Data      <= '0;
      o_DataValid <= 1'b0;
      o_Error     <= 1'b0;
      o_Busy      <= 1'b0;
    end else begin
      r_State     <= w_NextState;
      r_Buf       <= w_NextBuf;
      r_Count     <= w_NextCount;
      r_Idle      <= w_NextIdle;
      o_Data      <= w_NextData;
      o_DataValid <= w_NextValid;
      o_Error     <= w_NextError;
      o_Busy      <= (w_NextState == S_COLLECT);
    end
  end

  assign o_ByteCount = r_Count;

endmodule

// File: tb/tb_byte_to_word_packer.sv
// Directed bench: a 20-bit/timeout-8 instance driven from a vector table and
// a 16-bit/no-timeout instance for the indefinite-wait case.
module tb_byte_to_word_packer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;

  logic [7:0]  a_Byte = '0;
  logic        a_Valid = 1'b0;
  logic [19:0] a_Data;
  logic        a_DV, a_Err, a_Busy;
  logic [2:0]  a_Cnt;

  logic [7:0]  b_Byte = '0;
  logic        b_Valid = 1'b0;
  logic [15:0] b_Data;
  logic        b_DV, b_Err, b_Busy;
  logic [1:0]  b_Cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  byte_to_word_packer #(.DATAWIDTH(20), .TIMEOUT(8)) u_dut20 (
    .clk(clk), .rstn(rstn), .i_ByteIn(a_Byte), .i_ByteInValid(a_Valid),
    .o_Data(a_Data), .o_DataValid(a_DV), .o_Error(a_Err), .o_Busy(a_Busy),
    .o_ByteCount(a_Cnt)
  );

  byte_to_word_packer #(.DATAWIDTH(16), .TIMEOUT(0)) u_dut16 (
    .clk(clk), .rstn(rstn), .i_ByteIn(b_Byte), .i_ByteInValid(b_Valid),
    .o_Data(b_Data), .o_DataValid(b_DV), .o_Error(b_Err), .o_Busy(b_Busy),
    .o_ByteCount(b_Cnt)
  );

  typedef struct {
    logic        v;
    logic [7:0]  b;
    logic [19:0] data;
    logic        dv;
    logic        err;
    logic        busy;
    logic [2:0]  cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic [7:0] b, input logic [19:0] data,
                     input logic dv, input logic err, input logic busy,
                     input logic [2:0] cnt);
    vec_t t;
    t.v = v; t.b = b; t.data = data; t.dv = dv; t.err = err; t.busy = busy; t.cnt = cnt;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive on the falling edge, return 1 time unit after the rising edge.
  task automatic cyc(input logic va, input logic [7:0] ba, input logic vb, input logic [7:0] bb);
    @(negedge clk);
    a_Valid = va; a_Byte = ba;
    b_Valid = vb; b_Byte = bb;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [19:0] data, input logic dv,
                       input logic err, input logic busy, input logic [2:0] cnt);
    chk({tag, ".data"}, 32'(a_Data), 32'(data));
    chk({tag, ".dv"},   32'(a_DV),   32'(dv));
    chk({tag, ".err"},  32'(a_Err),  32'(err));
    chk({tag, ".busy"}, 32'(a_Busy), 32'(busy));
    chk({tag, ".cnt"},  32'(a_Cnt),  32'(cnt));
  endtask

  initial begin
    // Fill the vector table: two words, a dropped-nibble word, back-to-back,
    // timeout expiry, restart during o_Error, and a byte on the 8th idle edge.
    add(1, 8'h34, 20'h00000, 0, 0, 1, 1);
    add(1, 8'h12, 20'h00000, 0, 0, 1, 2);
    add(1, 8'h08, 20'h81234, 1, 0, 0, 0);
    add(0, 8'h00, 20'h81234, 0, 0, 0, 0);
    add(1, 8'h34, 20'h81234, 0, 0, 1, 1);
    add(1, 8'h12, 20'h81234, 0, 0, 1, 2);
    add(1, 8'hF8, 20'h81234, 1, 0, 0, 0);
    add(1, 8'h34, 20'h81234, 0, 0, 1, 1);
    add(1, 8'h12, 20'h81234, 0, 0, 1, 2);
    add(1, 8'h08, 20'h81234, 1, 0, 0, 0);
    add(1, 8'h45, 20'h81234, 0, 0, 1, 1);
    add(1, 8'h23, 20'h81234, 0, 0, 1, 2);
    add(1, 8'h01, 20'h12345, 1, 0, 0, 0);
    add(1, 8'hAA, 20'h12345, 0, 0, 1, 1);
    add(1, 8'hBB, 20'h12345, 0, 0, 1, 2);
    for (int i = 0; i < 7; i++) add(0, 8'h00, 20'h12345, 0, 0, 1, 2);
    add(0, 8'h00, 20'h12345, 0, 1, 0, 0);
    add(1, 8'h01, 20'h12345, 0, 0, 1, 1);
    add(1, 8'h02, 20'h12345, 0, 0, 1, 2);
    add(1, 8'h03, 20'h30201, 1, 0, 0, 0);
    add(1, 8'hAA, 20'h30201, 0, 0, 1, 1);
    add(1, 8'hBB, 20'h30201, 0, 0, 1, 2);
    for (int i = 0; i < 7; i++) add(0, 8'h00, 20'h30201, 0, 0, 1, 2);
    add(1, 8'hCC, 20'hCBBAA, 1, 0, 0, 0);
    add(0, 8'h00, 20'hCBBAA, 0, 0, 0, 0);

    #3;
    chk_a("rst20", 20'h0, 0, 0, 0, 0);
    chk("rst16.data", 32'(b_Data), 32'h0);
    chk("rst16.flags", 32'({b_DV, b_Err, b_Busy}), 32'h0);
    chk("rst16.cnt", 32'(b_Cnt), 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    foreach (vecs[i]) begin
      cyc(vecs[i].v, vecs[i].b, 1'b0, 8'h00);
      chk_a($sformatf("vec%0d", i), vecs[i].data, vecs[i].dv, vecs[i].err,
            vecs[i].busy, vecs[i].cnt);
    end

    // Asynchronous reset mid-word: outputs clear between edges, no error.
    cyc(1, 8'h11, 0, 8'h00);
    chk_a("mid.start", 20'hCBBAA, 0, 0, 1, 1);
    @(negedge clk);
    a_Valid = 1'b0;
    #2 rstn = 1'b0;
    #1 chk_a("mid.rst", 20'h0, 0, 0, 0, 0);
    #1 rstn = 1'b1;
    cyc(0, 8'h00, 0, 8'h00);
    chk_a("mid.idle", 20'h0, 0, 0, 0, 0);
    cyc(1, 8'h34, 0, 8'h00);
    cyc(1, 8'h12, 0, 8'h00);
    chk_a("mid.b2", 20'h0, 0, 0, 1, 2);
    cyc(1, 8'h08, 0, 8'h00);
    chk_a("mid.word", 20'h81234, 1, 0, 0, 0);

    // No-timeout instance: one byte, long stall, then the final byte.
    begin
      int unsigned err_seen;
      int unsigned busy_drop;
      err_seen = 0;
      busy_drop = 0;
      cyc(0, 8'h00, 1, 8'hCD);
      chk("nto.cnt1", 32'(b_Cnt), 32'd1);
      for (int i = 0; i < 100; i++) begin
        cyc(0, 8'h00, 0, 8'h00);
        if (b_Err) err_seen++;
        if (!b_Busy) busy_drop++;
      end
      chk("nto.err_seen", 32'(err_seen), 32'd0);
      chk("nto.busy_drop", 32'(busy_drop), 32'd0);
      chk("nto.cnt_hold", 32'(b_Cnt), 32'd1);
      cyc(0, 8'h00, 1, 8'hAB);
      chk("nto.data", 32'(b_Data), 32'h0000ABCD);
      chk("nto.dv", 32'(b_DV), 32'd1);
      chk("nto.err", 32'(b_Err), 32'd0);
      chk("nto.busy", 32'(b_Busy), 32'd0);
      cyc(0, 8'h00, 0, 8'h00);
      chk("nto.dv_pulse", 32'(b_DV), 32'd0);
      chk("nto.data_hold", 32'(b_Data), 32'h0000ABCD);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
